// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
//   sadd_state_t   : state encoding of the bit-serial adder controller
//   SADD_MAX_WIDTH : largest operand width the serial adder supports
package arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sadd_state_t;

  localparam int SADD_MAX_WIDTH = 32;

endpackage : arith_pkg

// File: rtl/fa_cell.sv
// One-bit full adder. This is the arithmetic cell that the serial adder
// controller time-shares across all bit positions.
// Ports:
//   a, b  : operand bits
//   c_in  : carry into this bit position
//   sum   : sum bit
//   c_out : carry out of this bit position
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule : fa_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. It adds two WIDTH-bit operands plus a
// carry-in over WIDTH clock cycles, LSB first, using one fa_cell.
// Ports:
//   clk   : clock; all state updates happen on the rising edge
//   rst   : synchronous active-high reset
//   start : request an addition (accepted in IDLE and in DONE)
//   a, b  : operands, captured when start is accepted
//   c_in  : carry-in, captured when start is accepted
//   busy  : high during the WIDTH cycles of the RUN state
//   done  : one-cycle pulse; sum/c_out are valid from this cycle on
//   sum   : result sum, held until the next completed addition
//   c_out : final carry-out, held with sum
module serial_add_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  sadd_state_t      state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             c_out_q,  c_out_d;

  logic             cell_sum;
  logic             cell_cout;
  logic [WIDTH-1:0] sum_shift;
  logic             load;

  fa_cell u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .sum   (cell_sum),
    .c_out (cell_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the
  // result has reached the LSB. A 1-bit register has nothing to shift.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign sum_shift = cell_sum;
    end else begin : g_shift_wn
      assign sum_shift = {cell_sum, sum_sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) load = 1'b1;
      end

      S_RUN: begin
        busy     = 1'b1;
        carry_d  = cell_cout;
        sum_sh_d = sum_shift;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Publish the result on the same edge that enters DONE so it is
        // already visible while done is high.
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          sum_d   = sum_shift;
          c_out_d = cell_cout;
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (start) load = 1'b1;
        else       state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Operand capture is shared between IDLE and the back-to-back DONE path.
    if (load) begin
      state_d = S_RUN;
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = c_in;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule : serial_add_ctrl
